wb_stage: RTL and testbench



---
 rtl/rv32_pkg.sv | 31 +++
 rtl/load_ext.sv | 26 ++
 rtl/wb_stage.sv | 88 ++++++++
 tb/tb_wb_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I constants: opcodes and the func3 codes used by write-back.
package rv32_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned OP_W   = 7;
    localparam int unsigned F3_W   = 3;

    // Opcodes
    localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OP_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;

    // Load widths
    localparam logic [F3_W-1:0] F3_LB  = 3'b000;
    localparam logic [F3_W-1:0] F3_LH  = 3'b001;
    localparam logic [F3_W-1:0] F3_LW  = 3'b010;
    localparam logic [F3_W-1:0] F3_LBU = 3'b100;
    localparam logic [F3_W-1:0] F3_LHU = 3'b101;

    // Set-compare
    localparam logic [F3_W-1:0] F3_SLT  = 3'b010;
    localparam logic [F3_W-1:0] F3_SLTU = 3'b011;

endpackage

// File: rtl/load_ext.sv
// Load extension: sign/zero-extends the aligned memory word according to func3.
//   i_func3      : load width/sign selector
//   i_read_data  : memory word, already aligned to bit 0
//   o_ext_data_c : extended value (combinational)
import rv32_pkg::*;

module load_ext (
    input  logic [F3_W-1:0] i_func3,
    input  logic [XLEN-1:0] i_read_data,
    output logic [XLEN-1:0] o_ext_data_c
);

    // Unlisted func3 codes fall back to a full-word load.
    always_comb begin
        o_ext_data_c = i_read_data;
        case (i_func3)
            F3_LB:   o_ext_data_c = {{24{i_read_data[7]}},  i_read_data[7:0]};
            F3_LH:   o_ext_data_c = {{16{i_read_data[15]}}, i_read_data[15:0]};
            F3_LW:   o_ext_data_c = i_read_data;
            F3_LBU:  o_ext_data_c = {24'b0, i_read_data[7:0]};
            F3_LHU:  o_ext_data_c = {16'b0, i_read_data[15:0]};
            default: o_ext_data_c = i_read_data;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: selects register-file write data/enable from memory-stage
// outputs and registers them for one cycle.
//   clk, rst        : clock, asynchronous active-low reset
//   rd, func3, opcode, read_data, lt, ltu, result, PC : memory-stage inputs
//   rd_WB, RegWrite, DataOut_WB : registered register-file write port
import rv32_pkg::*;

module wb_stage (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  rd,
    input  logic [F3_W-1:0]   func3,
    input  logic [OP_W-1:0]   opcode,
    input  logic [XLEN-1:0]   read_data,
    input  logic              lt,
    input  logic              ltu,
    input  logic [XLEN-1:0]   result,
    input  logic [XLEN-1:0]   PC,
    output logic [REG_W-1:0]  rd_WB,
    output logic              RegWrite,
    output logic [XLEN-1:0]   DataOut_WB
);

    logic [XLEN-1:0]  w_load;
    logic [XLEN-1:0]  w_data;
    logic             w_we;

    logic [REG_W-1:0] r_rd;
    logic             r_we;
    logic [XLEN-1:0]  r_data;

    load_ext u_load_ext (
        .i_func3      (func3),
        .i_read_data  (read_data),
        .o_ext_data_c (w_load)
    );

    // Write-data / enable selection by opcode.
    always_comb begin
        w_data = '0;
        w_we   = 1'b0;
        case (opcode)
            OP_R, OP_I: begin
                w_we = 1'b1;
                if (func3 == F3_SLT)
                    w_data = {31'b0, lt};
                else if (func3 == F3_SLTU)
                    w_data = {31'b0, ltu};
                else
                    w_data = result;
            end
            OP_LOAD: begin
                w_we   = 1'b1;
                w_data = w_load;
            end
            OP_JAL, OP_JALR: begin
                w_we   = 1'b1;
                w_data = PC + 32'd4;
            end
            OP_LUI, OP_AUIPC: begin
                w_we   = 1'b1;
                w_data = result;
            end
            default: begin
                w_we   = 1'b0;
                w_data = '0;
            end
        endcase
    end

    // Output registers; writes to x0 are suppressed here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd   <= '0;
            r_we   <= 1'b0;
            r_data <= '0;
        end else begin
            r_rd   <= rd;
            r_we   <= w_we && (rd != REG_W'(0));
            r_data <= w_data;
        end
    end

    assign rd_WB      = r_rd;
    assign RegWrite   = r_we;
    assign DataOut_WB = r_data;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed literal cases, back-to-back replay,
// and randomized stream checked every cycle against a behavioural model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rd = '0;
    logic [2:0]  func3 = '0;
    logic [6:0]  opcode = '0;
    logic [31:0] read_data = '0;
    logic        lt = 1'b0;
    logic        ltu = 1'b0;
    logic [31:0] result = '0;
    logic [31:0] PC = '0;
    logic [4:0]  rd_WB;
    logic        RegWrite;
    logic [31:0] DataOut_WB;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        lt;
        logic        ltu;
        logic [31:0] res;
        logic [31:0] pc;
    } instr_t;

    instr_t hist[$];

    wb_stage dut (
        .clk(clk), .rst(rst), .rd(rd), .func3(func3), .opcode(opcode),
        .read_data(read_data), .lt(lt), .ltu(ltu), .result(result), .PC(PC),
        .rd_WB(rd_WB), .RegWrite(RegWrite), .DataOut_WB(DataOut_WB)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Behavioural reference: {write-enable, data} straight from the ISA rules.
    function automatic logic [32:0] ref_wb(input instr_t i);
        logic [31:0] d;
        logic        we;
        d  = 32'd0;
        we = 1'b0;
        if (i.op == 7'b0110011 || i.op == 7'b0010011) begin
            we = 1'b1;
            if (i.f3 == 3'd2)      d = i.lt  ? 32'd1 : 32'd0;
            else if (i.f3 == 3'd3) d = i.ltu ? 32'd1 : 32'd0;
            else                   d = i.res;
        end else if (i.op == 7'b0000011) begin
            we = 1'b1;
            if (i.f3 == 3'd0) begin
                d = i.rdata % 256;
                if (d >= 128) d = d - 256;
            end else if (i.f3 == 3'd1) begin
                d = i.rdata % 65536;
                if (d >= 32768) d = d - 65536;
            end else if (i.f3 == 3'd4) d = i.rdata % 256;
            else if (i.f3 == 3'd5)     d = i.rdata % 65536;
            else                       d = i.rdata;
        end else if (i.op == 7'b1101111 || i.op == 7'b1100111) begin
            we = 1'b1;
            d  = 32'(64'(i.pc) + 64'd4);
        end else if (i.op == 7'b0110111 || i.op == 7'b0010111) begin
            we = 1'b1;
            d  = i.res;
        end
        if (i.rd == 5'd0) we = 1'b0;
        return {we, d};
    endfunction

    function automatic instr_t cur_in();
        instr_t i;
        i.op = opcode; i.f3 = func3; i.rd = rd; i.rdata = read_data;
        i.lt = lt; i.ltu = ltu; i.res = result; i.pc = PC;
        return i;
    endfunction

    // Model outputs, tracking the reset and capture rules.
    logic [4:0]  m_rd   = '0;
    logic        m_we   = 1'b0;
    logic [31:0] m_data = '0;

    always @(posedge clk or negedge rst) begin
        logic [32:0] r;
        if (!rst) begin
            m_rd   <= '0;
            m_we   <= 1'b0;
            m_data <= '0;
        end else begin
            r = ref_wb(cur_in());
            m_rd   <= rd;
            m_we   <= r[32];
            m_data <= r[31:0];
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("model_rd_WB",      32'(rd_WB),    32'(m_rd));
        chk("model_RegWrite",   32'(RegWrite), 32'(m_we));
        chk("model_DataOut_WB", DataOut_WB,    m_data);
    end

    task automatic set_in(input instr_t i);
        opcode = i.op; func3 = i.f3; rd = i.rd; read_data = i.rdata;
        lt = i.lt; ltu = i.ltu; result = i.res; PC = i.pc;
    endtask

    function automatic instr_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] r,
                                  input logic [31:0] rdata, input logic l, input logic lu,
                                  input logic [31:0] res, input logic [31:0] pc);
        instr_t i;
        i.op = op; i.f3 = f3; i.rd = r; i.rdata = rdata;
        i.lt = l; i.ltu = lu; i.res = res; i.pc = pc;
        return i;
    endfunction

    function automatic instr_t rand_in();
        logic [6:0] ops [12];
        instr_t i;
        int k;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0000011, 7'b1101111, 7'b1100111,
                7'b0110111, 7'b0010111, 7'b0100011, 7'b1100011, 7'b0000000, 7'b1111111};
        k = int'($urandom_range(0, 12));
        i.op    = (k == 12) ? 7'($urandom) : ops[k];
        i.f3    = 3'($urandom);
        i.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        i.rdata = $urandom;
        i.lt    = 1'($urandom);
        i.ltu   = 1'($urandom);
        i.res   = $urandom;
        i.pc    = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : $urandom;
        return i;
    endfunction

    // Directed instruction with hand-computed expectations, one cycle latency.
    task automatic step(input string name, input instr_t i, input logic [4:0] e_rd,
                        input logic e_we, input logic [31:0] e_data);
        @(posedge clk); #1;
        set_in(i);
        hist.push_back(i);
        @(posedge clk); #2;
        chk({name, "_rd_WB"},      32'(rd_WB),    32'(e_rd));
        chk({name, "_RegWrite"},   32'(RegWrite), 32'(e_we));
        chk({name, "_DataOut_WB"}, DataOut_WB,    e_data);
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_rd_WB"},      32'(rd_WB),    32'd0);
        chk({name, "_RegWrite"},   32'(RegWrite), 32'd0);
        chk({name, "_DataOut_WB"}, DataOut_WB,    32'd0);
    endtask

    localparam logic [31:0] RES = 32'h98765432;

    initial begin
        #2 rst = 1'b0;
        // Reset held with arbitrary inputs.
        repeat (3) begin
            @(posedge clk); #1;
            set_in(rand_in());
            #1 chk_zero("in_reset");
        end
        @(posedge clk); #1;
        rst = 1'b1;
        set_in(mk(7'b0010011, 3'd0, 5'd1, 32'd0, 1'b0, 1'b0, RES, 32'd0));
        @(posedge clk); #2;
        chk("release_rd_WB",      32'(rd_WB),    32'd1);
        chk("release_RegWrite",   32'(RegWrite), 32'd1);
        chk("release_DataOut_WB", DataOut_WB,    RES);
        // Asynchronous mid-stream reset, checked before any edge.
        @(posedge clk); #1;
        rst = 1'b0;
        #1 chk_zero("async_reset");
        @(posedge clk); #1;
        rst = 1'b1;

        step("lw",    mk(7'b0000011, 3'd2, 5'd1, 32'h0BADC0DE, 1'b0, 1'b0, 32'd0, 32'd0), 5'd1, 1'b1, 32'h0BADC0DE);
        step("lb",    mk(7'b0000011, 3'd0, 5'd1, 32'h000000DE, 1'b0, 1'b0, 32'd0, 32'd0), 5'd1, 1'b1, 32'hFFFFFFDE);
        step("lbu",   mk(7'b0000011, 3'd4, 5'd1, 32'h000000DE, 1'b0, 1'b0, 32'd0, 32'd0), 5'd1, 1'b1, 32'h000000DE);
        step("lh",    mk(7'b0000011, 3'd1, 5'd1, 32'h00008001, 1'b0, 1'b0, 32'd0, 32'd0), 5'd1, 1'b1, 32'hFFFF8001);
        step("lhu",   mk(7'b0000011, 3'd5, 5'd1, 32'hFFFF8001, 1'b0, 1'b0, 32'd0, 32'd0), 5'd1, 1'b1, 32'h00008001);
        step("jal",   mk(7'b1101111, 3'd0, 5'd1, 32'd0, 1'b0, 1'b0, 32'd0, 32'h70000000), 5'd1, 1'b1, 32'h70000004);
        step("jalr",  mk(7'b1100111, 3'd0, 5'd1, 32'd0, 1'b0, 1'b0, 32'd0, 32'hFFFFFFFC), 5'd1, 1'b1, 32'h00000000);
        step("lui",   mk(7'b0110111, 3'd0, 5'd1, 32'd0, 1'b0, 1'b0, RES, 32'd0), 5'd1, 1'b1, RES);
        step("auipc", mk(7'b0010111, 3'd0, 5'd1, 32'd0, 1'b0, 1'b0, RES, 32'd0), 5'd1, 1'b1, RES);
        step("slt",   mk(7'b0110011, 3'd2, 5'd1, 32'd0, 1'b1, 1'b0, RES, 32'd0), 5'd1, 1'b1, 32'h00000001);
        step("sltiu", mk(7'b0010011, 3'd3, 5'd1, 32'd0, 1'b1, 1'b0, RES, 32'd0), 5'd1, 1'b1, 32'h00000000);
        step("add",   mk(7'b0110011, 3'd0, 5'd1, 32'd0, 1'b1, 1'b1, RES, 32'd0), 5'd1, 1'b1, RES);
        step("sw",    mk(7'b0100011, 3'd2, 5'd1, 32'h12345678, 1'b1, 1'b1, RES, 32'h100), 5'd1, 1'b0, 32'd0);
        step("beq",   mk(7'b1100011, 3'd0, 5'd1, 32'h12345678, 1'b1, 1'b1, RES, 32'h100), 5'd1, 1'b0, 32'd0);
        step("addi_x0", mk(7'b0010011, 3'd0, 5'd0, 32'd0, 1'b0, 1'b0, RES, 32'd0), 5'd0, 1'b0, RES);

        // Back-to-back replay of the directed set; the model checks each cycle.
        foreach (hist[k]) begin
            @(posedge clk); #1;
            set_in(hist[k]);
        end

        // Randomized stream with occasional asynchronous reset pulses.
        for (int n = 0; n < 800; n++) begin
            @(posedge clk); #1;
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b0;
                set_in(rand_in());
                #1 chk_zero("rand_async_reset");
                @(posedge clk); #1;
                rst = 1'b1;
            end
            set_in(rand_in());
        end
        @(posedge clk); #2;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
